// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter. Sends one byte per request as a start bit,
// 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. Bit
// timing comes from an internal baud counter running on the system clock.
module uart_tx_core #(
    parameter int CLK_DIV   = 5208,  // system clocks per bit, 2..65535
    parameter int PARITY    = 0,     // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1      // 1 or 2
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active low
    input  logic       TX_EN,
    input  logic [7:0] TX_DATA,
    output logic       TX_STATUS,
    output logic       TX_DONE,
    output logic       UART_TX
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [15:0] BAUD_LAST  = 16'(CLK_DIV - 1);
    localparam logic [1:0]  STOP_LAST  = 2'(STOP_BITS - 1);
    localparam logic [1:0]  PAR_MODE   = 2'(PARITY);
    localparam logic        HAS_PARITY = (PARITY != 32'sd0);

    // Parity bit over a byte: odd mode makes the total count of ones odd,
    // even mode makes it even; no-parity mode returns 0 (never transmitted).
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            2'd1:    p = ~(^data);
            2'd2:    p = ^data;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    logic [2:0]  state_r, state_s;
    logic [15:0] baud_r, baud_s;
    logic [2:0]  bit_r, bit_s;
    logic [1:0]  stop_r, stop_s;
    logic [7:0]  shift_r, shift_s;
    logic        parity_r, parity_s;
    logic        tx_r, tx_s;
    logic        status_r, status_s;
    logic        done_r, done_s;
    logic        wrap_s;

    // Next-state and next-output computation; everything leaves through flops.
    always_comb begin
        state_s  = state_r;
        baud_s   = baud_r;
        bit_s    = bit_r;
        stop_s   = stop_r;
        shift_s  = shift_r;
        parity_s = parity_r;
        tx_s     = tx_r;
        status_s = status_r;
        done_s   = 1'b0;
        wrap_s   = (baud_r == BAUD_LAST);

        case (state_r)
            ST_IDLE: begin
                if (TX_EN && status_r) begin
                    // Accept: latch the byte and drive the start bit right away.
                    shift_s  = TX_DATA;
                    parity_s = parity_bit(TX_DATA, PAR_MODE);
                    tx_s     = 1'b0;
                    status_s = 1'b0;
                    baud_s   = 16'd0;
                    bit_s    = 3'd0;
                    stop_s   = 2'd0;
                    state_s  = ST_START;
                end else begin
                    tx_s     = 1'b1;
                    status_s = 1'b1;
                end
            end
            ST_START: begin
                if (wrap_s) begin
                    baud_s  = 16'd0;
                    tx_s    = shift_r[0];
                    shift_s = {1'b0, shift_r[7:1]};
                    bit_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    baud_s  = baud_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (wrap_s) begin
                    baud_s = 16'd0;
                    if (bit_r == 3'd7) begin
                        if (HAS_PARITY) begin
                            tx_s    = parity_r;
                            state_s = ST_PARITY;
                        end else begin
                            tx_s    = 1'b1;
                            stop_s  = 2'd0;
                            state_s = ST_STOP;
                        end
                    end else begin
                        tx_s    = shift_r[0];
                        shift_s = {1'b0, shift_r[7:1]};
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            ST_PARITY: begin
                if (wrap_s) begin
                    baud_s  = 16'd0;
                    tx_s    = 1'b1;
                    stop_s  = 2'd0;
                    state_s = ST_STOP;
                end else begin
                    baud_s  = baud_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (wrap_s) begin
                    baud_s = 16'd0;
                    tx_s   = 1'b1;
                    if (stop_r == STOP_LAST) begin
                        // Last stop bit ends here: ready again on this very edge.
                        status_s = 1'b1;
                        done_s   = 1'b1;
                        stop_s   = 2'd0;
                        state_s  = ST_IDLE;
                    end else begin
                        stop_s   = stop_r + 2'd1;
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                baud_s   = 16'd0;
                bit_s    = 3'd0;
                stop_s   = 2'd0;
                tx_s     = 1'b1;
                status_s = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            baud_r   <= 16'd0;
            bit_r    <= 3'd0;
            stop_r   <= 2'd0;
            shift_r  <= 8'd0;
            parity_r <= 1'b0;
            tx_r     <= 1'b1;
            status_r <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            baud_r   <= baud_s;
            bit_r    <= bit_s;
            stop_r   <= stop_s;
            shift_r  <= shift_s;
            parity_r <= parity_s;
            tx_r     <= tx_s;
            status_r <= status_s;
            done_r   <= done_s;
        end
    end

    assign UART_TX   = tx_r;
    assign TX_STATUS = status_r;
    assign TX_DONE   = done_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed checks of uart_tx_core with CLK_DIV = 4 across
// four parameter sets (no parity, even, odd, two stop bits).
module tb_uart_tx_core;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic [3:0] en;
    logic [7:0] tx_data;
    logic [3:0] tx_line;
    logic [3:0] status;
    logic [3:0] done;

    int total;
    int bad;

    typedef struct {
        int         idx;    // 0: P0/S1, 1: even/S1, 2: odd/S1, 3: P0/S2
        logic [7:0] data;
        logic [11:0] exp;   // bits in send order, first bit at [11]
        int         nbits;
    } vec_t;

    vec_t vecs[8];

    uart_tx_core #(.CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .clk(clk), .reset(reset), .TX_EN(en[0]), .TX_DATA(tx_data),
        .TX_STATUS(status[0]), .TX_DONE(done[0]), .UART_TX(tx_line[0]));
    uart_tx_core #(.CLK_DIV(DIV), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .TX_EN(en[1]), .TX_DATA(tx_data),
        .TX_STATUS(status[1]), .TX_DONE(done[1]), .UART_TX(tx_line[1]));
    uart_tx_core #(.CLK_DIV(DIV), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .TX_EN(en[2]), .TX_DATA(tx_data),
        .TX_STATUS(status[2]), .TX_DONE(done[2]), .UART_TX(tx_line[2]));
    uart_tx_core #(.CLK_DIV(DIV), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .clk(clk), .reset(reset), .TX_EN(en[3]), .TX_DATA(tx_data),
        .TX_STATUS(status[3]), .TX_DONE(done[3]), .UART_TX(tx_line[3]));

    // 10 ns system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Called just after the accepting edge; checks every cycle up to and
    // including the edge where the last stop bit ends.
    task automatic check_frame(input int idx, input logic [11:0] exp, input int nbits);
        int len;
        int pos;
        len = nbits * DIV;
        for (int e = 0; e <= len; e++) begin
            @(negedge clk);
            if (e < len) begin
                pos = 11 - (e / DIV);
                chk("line", e, tx_line[idx], exp[pos]);
                chk("status_busy", e, status[idx], 1'b0);
                chk("done_low", e, done[idx], 1'b0);
            end else begin
                chk("line_end", e, tx_line[idx], 1'b1);
                chk("status_end", e, status[idx], 1'b1);
                chk("done_pulse", e, done[idx], 1'b1);
            end
        end
    endtask

    // One complete frame: idle check, request, frame check, pulse width check.
    task automatic run_frame(input int idx, input logic [7:0] data,
                             input logic [11:0] exp, input int nbits);
        @(negedge clk);
        chk("idle_line", -1, tx_line[idx], 1'b1);
        chk("idle_status", -1, status[idx], 1'b1);
        tx_data = data;
        en[idx] = 1'b1;
        @(posedge clk);
        #1;
        en[idx] = 1'b0;
        tx_data = ~data;    // must not disturb the frame
        check_frame(idx, exp, nbits);
        @(negedge clk);
        chk("done_one_cycle", nbits * DIV + 1, done[idx], 1'b0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        en      = 4'b0000;
        tx_data = 8'h00;

        vecs[0] = '{0, 8'h55, 12'b0101_0101_0100, 10};
        vecs[1] = '{1, 8'hA5, 12'b0101_0010_1010, 11};
        vecs[2] = '{2, 8'hA5, 12'b0101_0010_1110, 11};
        vecs[3] = '{3, 8'hFF, 12'b0111_1111_1110, 11};
        vecs[4] = '{0, 8'h3C, 12'b0001_1110_0100, 10};
        vecs[5] = '{1, 8'h00, 12'b0000_0000_0010, 11};
        vecs[6] = '{2, 8'h01, 12'b0100_0000_0010, 11};
        vecs[7] = '{0, 8'h0F, 12'b0111_1000_0100, 10};

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_line", i, tx_line[i], 1'b1);
            chk("rst_status", i, status[i], 1'b1);
            chk("rst_done", i, done[i], 1'b0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].idx, vecs[v].data, vecs[v].exp, vecs[v].nbits);
        end

        // Back-to-back: TX_EN held with 0x31 then 0x32, no idle gap
        @(negedge clk);
        tx_data = 8'h31;
        en[0]   = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h32;    // ignored until TX_STATUS returns high
        check_frame(0, 12'b0100_0110_0100, 10);
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        tx_data = 8'hFF;
        check_frame(0, 12'b0010_0110_0100, 10);
        @(negedge clk);
        chk("b2b_done_low", 0, done[0], 1'b0);

        // TX_EN pulses at clocks 10 and 20 of a frame are ignored
        @(negedge clk);
        tx_data = 8'h0F;
        en[0]   = 1'b1;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        fork
            check_frame(0, 12'b0111_1000_0100, 10);
            begin
                repeat (9) @(posedge clk);
                #1;
                tx_data = 8'h00;
                en[0]   = 1'b1;
                @(posedge clk);
                #1;
                en[0] = 1'b0;
                repeat (9) @(posedge clk);
                #1;
                en[0] = 1'b1;
                @(posedge clk);
                #1;
                en[0] = 1'b0;
            end
        join
        @(negedge clk);
        chk("ign_done_low", 0, done[0], 1'b0);

        // Reset at clock 18 of a frame
        @(negedge clk);
        tx_data = 8'h00;
        en[0]   = 1'b1;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("pre_rst_busy", 18, status[0], 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_line", 18, tx_line[0], 1'b1);
        chk("async_rst_status", 18, status[0], 1'b1);
        chk("async_rst_done", 18, done[0], 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_no_done", c, done[0], 1'b0);
            chk("post_rst_line", c, tx_line[0], 1'b1);
        end
        run_frame(0, 8'h3C, 12'b0001_1110_0100, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
